// File: rtl/q_bridge_pkg.sv
// Shared types and constants for the H-bridge burst sequencer.
// Drive patterns are packed as {Q1Q8, Q2Q7, Q3Q6, Q4Q5}.
package q_bridge_pkg;

  localparam int PW = 16;
  localparam int DW = 8;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    DRV_A,
    DEAD_A,
    DRV_B,
    DEAD_B,
    DONE
  } state_t;

  localparam logic [3:0] Q_POS = 4'b1010;
  localparam logic [3:0] Q_NEG = 4'b0101;
  localparam logic [3:0] Q_OFF = 4'b0000;

  function automatic logic [PW-1:0] clamp1(input logic [PW-1:0] v);
    return (v == '0) ? PW'(1) : v;
  endfunction

endpackage

// File: rtl/q_dwell_cnt.sv
// Reloadable dwell down-counter; zero marks the last cycle of a phase.
// Holds at zero until reloaded.
module q_dwell_cnt
  import q_bridge_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - PW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/q_bridge_seq.sv
// H-bridge RF burst sequencer with dead-time insertion and abort.
// Outputs are registered from the next-state decode.
module q_bridge_seq
  import q_bridge_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] half_period,
  input  logic [DW-1:0] dead_time,
  input  logic [CW-1:0] cycle_num,
  input  logic          phase_sel,
  output logic          Q1Q8,
  output logic          Q2Q7,
  output logic          Q3Q6,
  output logic          Q4Q5,
  output logic          sw_ctrl,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  state_t        st, st_nxt;
  logic [PW-1:0] hp_l, dt_l, dt_in;
  logic [CW-1:0] cn_l, cyc, cyc_nxt;
  logic          ph_l, ab_f, ab_nxt;
  logic          ld, dec, zero;
  logic [PW-1:0] ld_val;
  logic [3:0]    q_r, q_nxt, pol_a, pol_b;
  logic          take;

  assign dt_in = clamp1(PW'(dead_time));
  assign take  = start && !abort;
  assign pol_a = ph_l ? Q_NEG : Q_POS;
  assign pol_b = ph_l ? Q_POS : Q_NEG;

  q_dwell_cnt u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      hp_l    <= '0;
      dt_l    <= '0;
      cn_l    <= '0;
      ph_l    <= 1'b0;
      cyc     <= '0;
      ab_f    <= 1'b0;
      q_r     <= Q_OFF;
      sw_ctrl <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      st      <= st_nxt;
      cyc     <= cyc_nxt;
      ab_f    <= ab_nxt;
      q_r     <= q_nxt;
      sw_ctrl <= (st_nxt != IDLE) && (st_nxt != DONE);
      busy    <= (st_nxt != IDLE);
      done    <= (st_nxt == DONE);
      aborted <= (st_nxt == DONE) && ab_nxt;
      if (st == IDLE && take) begin
        hp_l <= clamp1(half_period);
        dt_l <= dt_in;
        cn_l <= cycle_num;
        ph_l <= phase_sel;
      end
    end
  end

  assign {Q1Q8, Q2Q7, Q3Q6, Q4Q5} = q_r;

  always_comb begin
    st_nxt  = st;
    cyc_nxt = cyc;
    ab_nxt  = ab_f;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
    unique case (st)
      IDLE: begin
        if (take) begin
          cyc_nxt = '0;
          ab_nxt  = 1'b0;
          if (cycle_num == '0) begin
            st_nxt = DONE;
          end else begin
            st_nxt = LEAD;
            ld     = 1'b1;
            ld_val = dt_in - PW'(1);
          end
        end
      end
      DONE: st_nxt = IDLE;
      default: begin
        // a second abort while already winding down is ignored
        if (abort && !ab_f) begin
          st_nxt = DEAD_B;
          ld     = 1'b1;
          ld_val = dt_l - PW'(1);
          ab_nxt = 1'b1;
        end else if (!zero) begin
          dec = 1'b1;
        end else begin
          ld = 1'b1;
          case (st)
            LEAD: begin
              st_nxt = DRV_A;
              ld_val = hp_l - PW'(1);
            end
            DRV_A: begin
              st_nxt = DEAD_A;
              ld_val = dt_l - PW'(1);
            end
            DEAD_A: begin
              st_nxt = DRV_B;
              ld_val = hp_l - PW'(1);
            end
            DRV_B: begin
              st_nxt = DEAD_B;
              ld_val = dt_l - PW'(1);
            end
            DEAD_B: begin
              if (ab_f || cyc == cn_l - CW'(1)) begin
                st_nxt = DONE;
                ld     = 1'b0;
              end else begin
                st_nxt  = DRV_A;
                ld_val  = hp_l - PW'(1);
                cyc_nxt = cyc + CW'(1);
              end
            end
            default: begin
              st_nxt = IDLE;
              ld     = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    q_nxt = Q_OFF;
    if (st_nxt == DRV_A)
      q_nxt = pol_a;
    else if (st_nxt == DRV_B)
      q_nxt = pol_b;
  end

endmodule
